vga_timing_monitor: RTL

- Passive monitor downstream of the VGA pattern/timing stage; taps the registered vga_hs/vs/de/r/g/b bus in the pixel clock domain.
- Measures per-frame timing (active width/height, line and frame totals) and a pixel checksum, and tracks lock against expected resolution.
- Exposes results through an 8-bit chip-select register port for the soft CPU and for on-board self-test.

---
 rtl/vga_mon_pkg.sv | 30 +++
 rtl/vga_timing_monitor_if.sv | 16 +
 rtl/vga_sync_edge.sv | 28 ++
 rtl/vga_timing_monitor.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/vga_mon_pkg.sv
// Shared definitions for the VGA timing monitor: register map, FSM state
// encoding and STATUS bit positions.
package vga_mon_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_SEEK    = 2'd1,
    ST_MEASURE = 2'd2
  } mon_state_e;

  localparam logic [3:0] A_STATUS    = 4'h0;
  localparam logic [3:0] A_CTRL      = 4'h1;
  localparam logic [3:0] A_WIDTH_L   = 4'h2;
  localparam logic [3:0] A_WIDTH_H   = 4'h3;
  localparam logic [3:0] A_HEIGHT_L  = 4'h4;
  localparam logic [3:0] A_HEIGHT_H  = 4'h5;
  localparam logic [3:0] A_HTOT_L    = 4'h6;
  localparam logic [3:0] A_HTOT_H    = 4'h7;
  localparam logic [3:0] A_VTOT_L    = 4'h8;
  localparam logic [3:0] A_VTOT_H    = 4'h9;
  localparam logic [3:0] A_CSUM_L    = 4'hA;
  localparam logic [3:0] A_CSUM_H    = 4'hB;
  localparam logic [3:0] A_FRAME_CNT = 4'hC;
  localparam logic [3:0] A_CLR       = 4'hD;

  localparam int STAT_LOCKED_BIT = 0;
  localparam int STAT_SNAP_BIT   = 1;
  localparam int STAT_ERR_BIT    = 2;

endpackage

// File: rtl/vga_timing_monitor_if.sv
// Chip-select register port of the timing monitor.
//   master: soft CPU / self-test side   slave: monitor side
// s_readdata is registered in the slave and valid one clock after a read.
interface vga_timing_monitor_if;
  logic       s_cs_n;
  logic [3:0] s_address;
  logic       s_write;
  logic [7:0] s_writedata;
  logic       s_read;
  logic [7:0] s_readdata;

  modport master (output s_cs_n, s_address, s_write, s_writedata, s_read,
                  input  s_readdata);
  modport slave  (input  s_cs_n, s_address, s_write, s_writedata, s_read,
                  output s_readdata);
endinterface

// File: rtl/vga_sync_edge.sv
// Registers one sync input and flags the cycle in which the registered copy
// has just entered its active level.
//   clk, reset_n : clock, async active-low reset
//   sync_in      : raw sync from the video bus
//   sync_edge    : one-cycle pulse on transition into level POL
module vga_sync_edge #(
  parameter bit POL = 1'b0
) (
  input  logic clk,
  input  logic reset_n,
  input  logic sync_in,
  output logic sync_edge
);
  logic s_q, s_q2;

  // Reset to the inactive level so an idle bus produces no edge on release.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s_q  <= ~POL;
      s_q2 <= ~POL;
    end else begin
      s_q  <= sync_in;
      s_q2 <= s_q;
    end
  end

  assign sync_edge = (s_q == POL) && (s_q2 != POL);
endmodule

// File: rtl/vga_timing_monitor.sv
// Passive VGA timing monitor. Measures active width/height, line/frame totals
// and a pixel checksum per frame, tracks lock against H_DISP x V_DISP and
// exposes the results on an 8-bit register port.
//   clk, reset_n      : pixel clock, async active-low reset
//   vid_hs/vs/de/r/g/b: tapped video bus
//   bus (slave)       : register port, registered read data
//   frame_done        : pulse the cycle after a snapshot is published
//   locked            : two consecutive frames matched the expected mode
module vga_timing_monitor
  import vga_mon_pkg::*;
#(
  parameter int H_DISP = 640,
  parameter int V_DISP = 480,
  parameter bit HS_POL = 1'b0,
  parameter bit VS_POL = 1'b0,
  parameter int CNT_W  = 12
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 vid_hs,
  input  logic                 vid_vs,
  input  logic                 vid_de,
  input  logic [7:0]           vid_r,
  input  logic [7:0]           vid_g,
  input  logic [7:0]           vid_b,
  vga_timing_monitor_if.slave  bus,
  output logic                 frame_done,
  output logic                 locked
);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] x);
    return (x == CNT_MAX) ? x : x + CNT_W'(1);
  endfunction

  // ---- input registers (aligned with the registered syncs) ----
  logic hs_edge, vs_edge, de_q;
  logic [7:0] r_q, g_q, b_q;

  vga_sync_edge #(.POL(HS_POL)) u_hs (.clk(clk), .reset_n(reset_n), .sync_in(vid_hs), .sync_edge(hs_edge));
  vga_sync_edge #(.POL(VS_POL)) u_vs (.clk(clk), .reset_n(reset_n), .sync_in(vid_vs), .sync_edge(vs_edge));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      de_q <= 1'b0; r_q <= '0; g_q <= '0; b_q <= '0;
    end else begin
      de_q <= vid_de; r_q <= vid_r; g_q <= vid_g; b_q <= vid_b;
    end
  end

  // ---- control FSM ----
  logic ctrl_enable, ctrl_freeze;
  mon_state_e state, state_nx;
  logic clr_cnt, hold_zero, frame_end, publish;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= ST_SEEK;
    else          state <= state_nx;
  end

  always_comb begin
    state_nx  = state;
    hold_zero = (state != ST_MEASURE);
    frame_end = (state == ST_MEASURE) && vs_edge;
    publish   = frame_end && !ctrl_freeze;
    clr_cnt   = hold_zero || vs_edge;
    if (!ctrl_enable) state_nx = ST_IDLE;
    else begin
      case (state)
        ST_IDLE:    state_nx = ST_SEEK;
        ST_SEEK:    if (vs_edge) state_nx = ST_MEASURE;
        ST_MEASURE: state_nx = ST_MEASURE;
        default:    state_nx = ST_SEEK;
      endcase
    end
  end

  // ---- measurement datapath ----
  logic [CNT_W-1:0] h_cnt, w_cnt, h_total_run, w_ref, height, v_total;
  logic [15:0]      csum;
  logic             line_err;

  // "_nx" values include the line closed by an HS edge this cycle, so a
  // coincident VS edge publishes a frame that already contains that line.
  logic [CNT_W-1:0] w_ref_nx, height_nx, v_total_nx, htot_nx;
  logic [15:0]      csum_nx;
  logic             line_err_nx, ln_close, ln_first, frame_match;

  always_comb begin
    ln_close    = hs_edge && (w_cnt != '0);
    ln_first    = ln_close && (height == '0);
    w_ref_nx    = ln_first ? w_cnt : w_ref;
    height_nx   = ln_close ? sat_inc(height) : height;
    line_err_nx = line_err | (ln_close && !ln_first && (w_cnt != w_ref));
    v_total_nx  = hs_edge ? sat_inc(v_total) : v_total;
    htot_nx     = hs_edge ? sat_inc(h_cnt) : h_total_run;
    csum_nx     = csum + (de_q ? (16'(r_q) + 16'(g_q) + 16'(b_q)) : 16'd0);
    frame_match = (w_ref_nx == CNT_W'(H_DISP)) && (height_nx == CNT_W'(V_DISP)) && !line_err_nx;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      h_cnt <= '0; w_cnt <= '0; h_total_run <= '0; w_ref <= '0;
      height <= '0; v_total <= '0; csum <= '0; line_err <= 1'b0;
    end else if (clr_cnt) begin
      h_cnt <= '0; w_cnt <= '0; w_ref <= '0;
      height <= '0; v_total <= '0; csum <= '0; line_err <= 1'b0;
      h_total_run <= hold_zero ? '0 : htot_nx;
    end else begin
      h_cnt       <= hs_edge ? '0 : sat_inc(h_cnt);
      w_cnt       <= hs_edge ? CNT_W'(de_q) : (de_q ? sat_inc(w_cnt) : w_cnt);
      h_total_run <= htot_nx;
      w_ref       <= w_ref_nx;
      height      <= height_nx;
      v_total     <= v_total_nx;
      csum        <= csum_nx;
      line_err    <= line_err_nx;
    end
  end

  // ---- snapshot, lock and register port ----
  logic [CNT_W-1:0] snap_w, snap_h, snap_ht, snap_vt;
  logic [15:0]      snap_cs;
  logic [7:0]       frame_cnt, rd_mux;
  logic             snap_valid, err_sticky, streak;
  logic             wr, rd, clr_wr;
  logic [15:0]      w16, h16, ht16, vt16;
  logic             unused_wd;

  assign wr        = !bus.s_cs_n && bus.s_write;
  assign rd        = !bus.s_cs_n && bus.s_read;
  assign clr_wr    = wr && (bus.s_address == A_CLR) && bus.s_writedata[0];
  assign unused_wd = ^bus.s_writedata[7:2];
  assign w16  = 16'(snap_w);
  assign h16  = 16'(snap_h);
  assign ht16 = 16'(snap_ht);
  assign vt16 = 16'(snap_vt);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      snap_w <= '0; snap_h <= '0; snap_ht <= '0; snap_vt <= '0; snap_cs <= '0;
      frame_cnt <= '0; frame_done <= 1'b0; snap_valid <= 1'b0;
      locked <= 1'b0; streak <= 1'b0; err_sticky <= 1'b0;
      ctrl_enable <= 1'b1; ctrl_freeze <= 1'b0;
    end else begin
      frame_done <= publish;
      if (publish) begin
        snap_w <= w_ref_nx; snap_h <= height_nx; snap_ht <= htot_nx;
        snap_vt <= v_total_nx; snap_cs <= csum_nx;
        frame_cnt <= frame_cnt + 8'd1;
        snap_valid <= 1'b1;
      end
      if (frame_end) begin
        if (frame_match) begin
          if (streak) locked <= 1'b1;
          streak <= 1'b1;
        end else begin
          streak <= 1'b0;
          locked <= 1'b0;
          if (locked) err_sticky <= 1'b1;
        end
      end
      if (!ctrl_enable) begin
        snap_valid <= 1'b0; locked <= 1'b0; streak <= 1'b0;
      end
      if (clr_wr) err_sticky <= 1'b0;
      if (wr && (bus.s_address == A_CTRL)) begin
        ctrl_enable <= bus.s_writedata[0];
        ctrl_freeze <= bus.s_writedata[1];
      end
    end
  end

  always_comb begin
    rd_mux = 8'h00;
    case (bus.s_address)
      A_STATUS: begin
        rd_mux[STAT_LOCKED_BIT] = locked;
        rd_mux[STAT_SNAP_BIT]   = snap_valid;
        rd_mux[STAT_ERR_BIT]    = err_sticky;
      end
      A_CTRL:      rd_mux = {6'b0, ctrl_freeze, ctrl_enable};
      A_WIDTH_L:   rd_mux = w16[7:0];
      A_WIDTH_H:   rd_mux = w16[15:8];
      A_HEIGHT_L:  rd_mux = h16[7:0];
      A_HEIGHT_H:  rd_mux = h16[15:8];
      A_HTOT_L:    rd_mux = ht16[7:0];
      A_HTOT_H:    rd_mux = ht16[15:8];
      A_VTOT_L:    rd_mux = vt16[7:0];
      A_VTOT_H:    rd_mux = vt16[15:8];
      A_CSUM_L:    rd_mux = snap_cs[7:0];
      A_CSUM_H:    rd_mux = snap_cs[15:8];
      A_FRAME_CNT: rd_mux = frame_cnt;
      default:     rd_mux = 8'h00;
    endcase
  end

  // Read data sampled from pre-write state, so a same-cycle write is not seen.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)  bus.s_readdata <= '0;
    else if (rd)   bus.s_readdata <= rd_mux;
  end
endmodule
